// File: rtl/ros2_sub_msg_stream_pkg.sv
// Shared constants and helpers for the ROS2 subscriber message replay block.
// The app-data buffer depth here must match the ros2_ether build configuration.
package ros2_sub_msg_stream_pkg;

  localparam int ROS2_MAX_APP_DATA_LEN = 64;
  localparam int BYTE_W                = 8;
  localparam int REP_ID_W              = 16;

  // Clamp an 8-bit message length to the buffer depth (9-bit to allow a 256-byte buffer)
  function automatic logic [8:0] clamp_len(input logic [7:0] len, input logic [8:0] max_len);
    if ({1'b0, len} > max_len) begin
      return max_len;
    end else begin
      return {1'b0, len};
    end
  endfunction

endpackage

// File: rtl/ros2_sub_msg_ram.sv
// Simple dual-port message buffer: one write port, one synchronous read port.
module ros2_sub_msg_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_int,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [DEPTH];

  // Write port; contents are deliberately left unreset
  always_ff @(posedge clk_int) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge clk_int) begin
    if (re) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/ros2_sub_msg_stream.sv
// Replays each received ROS2 subscriber message from the shared buffer as a
// byte stream tagged with the writer ID, holding the buffer lock throughout.
module ros2_sub_msg_stream
  import ros2_sub_msg_stream_pkg::*;
#(
  parameter int  MAX_LEN = ROS2_MAX_APP_DATA_LEN,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic                clk_int,
  input  logic                rst_n,
  input  logic [AW-1:0]       wr_addr,
  input  logic                wr_ce,
  input  logic                wr_we,
  input  logic [BYTE_W-1:0]   wr_data,
  input  logic [7:0]          msg_len,
  input  logic [REP_ID_W-1:0] msg_rep_id,
  input  logic                msg_recv,
  output logic                buf_req,
  input  logic                buf_grant,
  output logic                buf_rel,
  output logic [BYTE_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [REP_ID_W-1:0] m_tuser,
  output logic                busy,
  output logic [7:0]          overrun_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_REL    = 3'd4;

  localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

  logic [2:0]          state_r, state_next_s;
  logic                pending_r;
  logic [7:0]          overrun_cnt_r;
  logic [AW:0]         len_q_r, idx_r, idx_inc_s, len_clamp_s;
  logic                rd_en_s;
  logic [AW-1:0]       rd_addr_s;
  logic [BYTE_W-1:0]   rd_data_s;
  logic [BYTE_W-1:0]   m_tdata_r;
  logic                m_tvalid_r, m_tlast_r, buf_req_r, buf_rel_r, busy_r;
  logic [REP_ID_W-1:0] m_tuser_r;

  // idx is one bit wider than the address so a full 256-byte buffer cannot wrap
  assign idx_inc_s   = idx_r + {{AW{1'b0}}, 1'b1};
  assign len_clamp_s = (AW+1)'(clamp_len(msg_len, MAX_LEN9));

  ros2_sub_msg_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_ram (
    .clk_int (clk_int),
    .we      (wr_ce & wr_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Next-state and buffer read-address decode
  always_comb begin
    state_next_s = state_r;
    rd_en_s      = 1'b0;
    rd_addr_s    = {AW{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (msg_recv || pending_r) begin
          state_next_s = S_REQ;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (!buf_grant) begin
          state_next_s = S_REQ;
        end else if (len_clamp_s == {(AW+1){1'b0}}) begin
          state_next_s = S_REL;
        end else begin
          state_next_s = S_FETCH;
          rd_en_s      = 1'b1;
        end
      end
      S_FETCH: begin
        if (buf_grant) begin
          state_next_s = S_STREAM;
        end else begin
          state_next_s = S_REL;
        end
      end
      S_STREAM: begin
        if (!buf_grant) begin
          state_next_s = S_REL;
        end else if (!m_tready) begin
          state_next_s = S_STREAM;
        end else if (m_tlast_r) begin
          state_next_s = S_REL;
        end else begin
          state_next_s = S_FETCH;
          rd_en_s      = 1'b1;
          rd_addr_s    = idx_inc_s[AW-1:0];
        end
      end
      S_REL: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, handshake and stream output registers
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      buf_req_r  <= 1'b0;
      buf_rel_r  <= 1'b0;
      len_q_r    <= {(AW+1){1'b0}};
      idx_r      <= {(AW+1){1'b0}};
      m_tdata_r  <= {BYTE_W{1'b0}};
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tuser_r  <= {REP_ID_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      busy_r    <= (state_next_s != S_IDLE);
      buf_req_r <= (state_next_s != S_IDLE);
      buf_rel_r <= (state_r == S_REL);
      case (state_r)
        S_REQ: begin
          if (buf_grant) begin
            len_q_r   <= len_clamp_s;
            m_tuser_r <= msg_rep_id;
            idx_r     <= {(AW+1){1'b0}};
          end
        end
        S_FETCH: begin
          if (buf_grant) begin
            m_tdata_r  <= rd_data_s;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= (idx_inc_s == len_q_r);
          end
        end
        S_STREAM: begin
          if (!buf_grant || m_tready) begin
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
          end
          if (buf_grant && m_tready && !m_tlast_r) begin
            idx_r <= idx_inc_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Notification capture: one pending slot, extra notifications are counted and dropped
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      pending_r     <= 1'b0;
      overrun_cnt_r <= 8'd0;
    end else if (state_r == S_IDLE) begin
      pending_r <= pending_r & msg_recv;
    end else if (msg_recv) begin
      if (!pending_r) begin
        pending_r <= 1'b1;
      end else if (overrun_cnt_r != 8'hFF) begin
        overrun_cnt_r <= overrun_cnt_r + 8'd1;
      end
    end
  end

  assign buf_req     = buf_req_r;
  assign buf_rel     = buf_rel_r;
  assign busy        = busy_r;
  assign m_tdata     = m_tdata_r;
  assign m_tvalid    = m_tvalid_r;
  assign m_tlast     = m_tlast_r;
  assign m_tuser     = m_tuser_r;
  assign overrun_cnt = overrun_cnt_r;

endmodule

// File: tb/tb_ros2_sub_msg_stream.sv
// Directed bench for ros2_sub_msg_stream with a 64-byte buffer; a small
// ros2_ether stand-in writes messages, pulses recv and drives the grant.
module tb_ros2_sub_msg_stream;

  logic        clk_int = 1'b0;
  logic        rst_n;
  logic [5:0]  wr_addr;
  logic        wr_ce, wr_we;
  logic [7:0]  wr_data, msg_len;
  logic [15:0] msg_rep_id;
  logic        msg_recv, buf_req, buf_grant, buf_rel;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [15:0] m_tuser;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the last collect() call
  logic [7:0]  got_data[$];
  logic [63:0] last_mask;
  int          n_last, first_valid, rel_cyc, rel_cnt, stab_err;
  bit          timed_out;
  logic        req_at_rel;

  always #5 clk_int = ~clk_int;

  ros2_sub_msg_stream #(.MAX_LEN(64)) dut (
    .clk_int(clk_int), .rst_n(rst_n), .wr_addr(wr_addr), .wr_ce(wr_ce), .wr_we(wr_we),
    .wr_data(wr_data), .msg_len(msg_len), .msg_rep_id(msg_rep_id), .msg_recv(msg_recv),
    .buf_req(buf_req), .buf_grant(buf_grant), .buf_rel(buf_rel), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  task automatic step();
    @(posedge clk_int);
    #1;
  endtask

  task automatic write_byte(input logic [5:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; wr_ce = 1'b1; wr_we = 1'b1;
    step();
    wr_ce = 1'b0; wr_we = 1'b0;
  endtask

  task automatic pulse_recv();
    msg_recv = 1'b1;
    step();
    msg_recv = 1'b0;
  endtask

  // Grant is raised by the caller; cycle 1 is the edge that samples it.
  // mode 0: ready always, 1: ready toggles each cycle, 2: ready one cycle in three
  task automatic collect(input int mode, input int budget);
    int cyc, tail;
    bit held;
    logic [7:0] pd;
    logic pl;
    got_data.delete();
    last_mask = 64'd0; n_last = 0; first_valid = -1; rel_cyc = -1; rel_cnt = 0;
    stab_err = 0; timed_out = 1'b0; req_at_rel = 1'bx;
    held = 1'b0; tail = -1; cyc = 0; pd = 8'd0; pl = 1'b0;
    m_tready = (mode == 0);
    while (tail != 0) begin
      step();
      cyc++;
      if (held && (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl)) stab_err++;
      if (m_tvalid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (buf_rel === 1'b1) begin
        rel_cnt++;
        if (rel_cyc < 0) begin
          rel_cyc = cyc; req_at_rel = buf_req; buf_grant = 1'b0; tail = 4;
        end
      end
      if (mode == 1) m_tready = ~m_tready;
      else if (mode == 2) m_tready = (cyc % 3 == 0);
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (m_tlast === 1'b1) begin
          n_last++;
          if (got_data.size() < 64) last_mask[got_data.size()] = 1'b1;
        end
        got_data.push_back(m_tdata);
      end
      held = (m_tvalid === 1'b1) && !m_tready;
      pd = m_tdata; pl = m_tlast;
      if (tail > 0) tail--;
      if (cyc >= budget && rel_cyc < 0) begin
        timed_out = 1'b1; buf_grant = 1'b0; tail = 0;
      end
    end
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++; if (buf_req !== 1'b0) begin n_err++; $display("FAIL rst_buf_req: got %b expected 0", buf_req); end
    n_cmp++; if (buf_rel !== 1'b0) begin n_err++; $display("FAIL rst_buf_rel: got %b expected 0", buf_rel); end
    n_cmp++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_valid_last: got %b%b expected 00", m_tvalid, m_tlast); end
    n_cmp++; if (m_tdata !== 8'h00 || m_tuser !== 16'h0000) begin n_err++; $display("FAIL rst_data_user: got %h/%h expected 00/0000", m_tdata, m_tuser); end
    n_cmp++; if (busy !== 1'b0 || overrun_cnt !== 8'd0) begin n_err++; $display("FAIL rst_busy_ovr: got %b/%0d expected 0/0", busy, overrun_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_hello();
    logic [7:0] exp_b[5] = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
    for (int i = 0; i < 5; i++) write_byte(6'(i), exp_b[i]);
    pulse_recv();
    repeat (3) step();
    n_cmp++; if (buf_req !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL t1_req_before_grant: got %b%b expected 11", buf_req, busy); end
    msg_len = 8'd5; msg_rep_id = 16'h1234; buf_grant = 1'b1;
    collect(0, 200);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL t1_timeout: got %b expected 0", timed_out); end
    n_cmp++; if (got_data.size() != 5) begin n_err++; $display("FAIL t1_count: got %0d expected 5", got_data.size()); end
    for (int i = 0; i < 5 && i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== exp_b[i]) begin n_err++; $display("FAIL t1_byte%0d: got %h expected %h", i, got_data[i], exp_b[i]); end
    end
    n_cmp++; if (last_mask !== 64'h10 || n_last != 1) begin n_err++; $display("FAIL t1_tlast: got mask %h n %0d expected 10/1", last_mask, n_last); end
    n_cmp++; if (m_tuser !== 16'h1234) begin n_err++; $display("FAIL t1_tuser: got %h expected 1234", m_tuser); end
    n_cmp++; if (first_valid != 2) begin n_err++; $display("FAIL t1_first_valid: got %0d expected 2", first_valid); end
    // two cycles to the first byte, two per byte, rel the cycle after the last accept
    n_cmp++; if (rel_cyc != 12) begin n_err++; $display("FAIL t1_rel_cycle: got %0d expected 12", rel_cyc); end
    n_cmp++; if (rel_cnt != 1) begin n_err++; $display("FAIL t1_rel_pulses: got %0d expected 1", rel_cnt); end
    n_cmp++; if (req_at_rel !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t1_req_busy_after: got %b%b expected 00", req_at_rel, busy); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_b[5] = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
    for (int m = 1; m <= 2; m++) begin
      pulse_recv();
      msg_len = 8'd5; msg_rep_id = 16'h2200 + 16'(m); buf_grant = 1'b1;
      collect(m, 200);
      n_cmp++; if (got_data.size() != 5 || timed_out) begin n_err++; $display("FAIL t2_count_m%0d: got %0d (timeout %b) expected 5", m, got_data.size(), timed_out); end
      for (int i = 0; i < 5 && i < got_data.size(); i++) begin
        n_cmp++; if (got_data[i] !== exp_b[i]) begin n_err++; $display("FAIL t2_byte%0d_m%0d: got %h expected %h", i, m, got_data[i], exp_b[i]); end
      end
      n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL t2_stable_m%0d: got %0d unstable cycles expected 0", m, stab_err); end
      n_cmp++; if (last_mask !== 64'h10 || rel_cnt != 1) begin n_err++; $display("FAIL t2_last_rel_m%0d: got %h/%0d expected 10/1", m, last_mask, rel_cnt); end
    end
  endtask

  task automatic test_zero_len();
    pulse_recv();
    step();
    msg_len = 8'd0; msg_rep_id = 16'hBEEF; buf_grant = 1'b1;
    collect(0, 50);
    n_cmp++; if (got_data.size() != 0 || first_valid != -1) begin n_err++; $display("FAIL t3_no_beat: got %0d beats first %0d expected 0/-1", got_data.size(), first_valid); end
    n_cmp++; if (rel_cyc != 2 || rel_cnt != 1) begin n_err++; $display("FAIL t3_rel: got cyc %0d n %0d expected 2/1", rel_cyc, rel_cnt); end
    n_cmp++; if (m_tuser !== 16'hBEEF) begin n_err++; $display("FAIL t3_tuser: got %h expected beef", m_tuser); end
  endtask

  task automatic test_clamp();
    int bad;
    for (int i = 0; i < 64; i++) write_byte(6'(i), 8'(i * 3 + 1));
    pulse_recv();
    msg_len = 8'd200; msg_rep_id = 16'h0064; buf_grant = 1'b1;
    collect(0, 400);
    n_cmp++; if (got_data.size() != 64 || timed_out) begin n_err++; $display("FAIL t4_count: got %0d (timeout %b) expected 64", got_data.size(), timed_out); end
    bad = 0;
    for (int i = 0; i < 64 && i < got_data.size(); i++) if (got_data[i] !== 8'(i * 3 + 1)) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL t4_bytes: got %0d wrong bytes expected 0", bad); end
    n_cmp++; if (last_mask !== 64'h8000_0000_0000_0000 || n_last != 1) begin n_err++; $display("FAIL t4_tlast: got %h/%0d expected 8000000000000000/1", last_mask, n_last); end
    n_cmp++; if (rel_cyc != 130) begin n_err++; $display("FAIL t4_rel_cycle: got %0d expected 130", rel_cyc); end
  endtask

  task automatic test_back_to_back();
    write_byte(6'd0, 8'h41);
    write_byte(6'd1, 8'h42);
    pulse_recv();
    pulse_recv();
    pulse_recv();
    n_cmp++; if (overrun_cnt !== 8'd1) begin n_err++; $display("FAIL t5_overrun: got %0d expected 1", overrun_cnt); end
    msg_len = 8'd2; msg_rep_id = 16'h0505; buf_grant = 1'b1;
    collect(0, 100);
    n_cmp++; if (got_data.size() != 2 || rel_cnt != 1) begin n_err++; $display("FAIL t5_first: got %0d beats %0d rels expected 2/1", got_data.size(), rel_cnt); end
    n_cmp++; if (buf_req !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL t5_pending_req: got %b%b expected 11", buf_req, busy); end
    buf_grant = 1'b1;
    collect(0, 100);
    n_cmp++; if (got_data.size() != 2 || got_data[0] !== 8'h41 || got_data[1] !== 8'h42) begin n_err++; $display("FAIL t5_second: got %0d beats expected 41 42", got_data.size()); end
    n_cmp++; if (busy !== 1'b0 || overrun_cnt !== 8'd1) begin n_err++; $display("FAIL t5_idle_after: got busy %b ovr %0d expected 0/1", busy, overrun_cnt); end
    pulse_recv();
    msg_recv = 1'b1;
    repeat (300) step();
    msg_recv = 1'b0;
    n_cmp++; if (overrun_cnt !== 8'd255) begin n_err++; $display("FAIL t5_saturate: got %0d expected 255", overrun_cnt); end
    for (int k = 0; k < 2; k++) begin
      buf_grant = 1'b1;
      collect(0, 100);
    end
    n_cmp++; if (busy !== 1'b0 || overrun_cnt !== 8'd255) begin n_err++; $display("FAIL t5_drain: got busy %b ovr %0d expected 0/255", busy, overrun_cnt); end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_b[3] = '{8'h55, 8'h66, 8'h77};
    write_byte(6'd0, 8'h11);
    pulse_recv();
    m_tready = 1'b0; msg_len = 8'd4; msg_rep_id = 16'h0707; buf_grant = 1'b1;
    repeat (4) step();
    n_cmp++; if (m_tvalid !== 1'b1 || buf_req !== 1'b1) begin n_err++; $display("FAIL t6_stalled: got valid %b req %b expected 11", m_tvalid, buf_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (buf_req !== 1'b0 || m_tvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t6_async_drop: got req %b valid %b busy %b expected 000", buf_req, m_tvalid, busy); end
    buf_grant = 1'b0;
    step();
    n_cmp++; if (buf_rel !== 1'b0 || overrun_cnt !== 8'd0 || m_tuser !== 16'h0000) begin n_err++; $display("FAIL t6_in_reset: got rel %b ovr %0d user %h expected 0/0/0000", buf_rel, overrun_cnt, m_tuser); end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) write_byte(6'(i), exp_b[i]);
    pulse_recv();
    msg_len = 8'd3; msg_rep_id = 16'h0606; buf_grant = 1'b1;
    collect(0, 100);
    n_cmp++; if (got_data.size() != 3 || rel_cyc != 8) begin n_err++; $display("FAIL t6_fresh_count: got %0d beats rel at %0d expected 3/8", got_data.size(), rel_cyc); end
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== exp_b[i]) begin n_err++; $display("FAIL t6_byte%0d: got %h expected %h", i, got_data[i], exp_b[i]); end
    end
    n_cmp++; if (last_mask !== 64'h4 || m_tuser !== 16'h0606) begin n_err++; $display("FAIL t6_last_user: got %h/%h expected 4/0606", last_mask, m_tuser); end
  endtask

  initial begin
    rst_n = 1'b0; wr_addr = 6'd0; wr_ce = 1'b0; wr_we = 1'b0; wr_data = 8'd0;
    msg_len = 8'd0; msg_rep_id = 16'd0; msg_recv = 1'b0; buf_grant = 1'b0; m_tready = 1'b0;
    test_reset();
    test_hello();
    test_stall();
    test_zero_len();
    test_clamp();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
